// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier, one product bit per cycle.
// B holds the multiplier, M latches the multiplicand from S at CLEAR, and the
// product accumulates in {A,B} with the extension bit in X.
// Build option: define MULT_SIGNED_EN for two's-complement operands
// (final-iteration subtract, X = product sign); otherwise the unsigned
// build is produced (all iterations add, X = 0 at Done).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting; ClearA_LoadB loads B from S, Run starts a multiply
// CLEAR   | A and X cleared, multiplicand latched into M, counter zeroed
// COMPUTE | one add/shift iteration per cycle, WIDTH cycles
// DONE    | result held until Run is released

module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ClearA_LoadB,
    input  logic             Run,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             Busy,
    output logic             Done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CLEAR   = 2'd1;
    localparam logic [1:0] COMPUTE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] m_reg;
    logic             x_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   p;
    logic [WIDTH:0]   m_ext;
    logic             last;

    // Partial-product update for the current iteration: {X,A} plus (or, on
    // the last signed iteration, minus) the multiplicand when B[0] is set.
    always_comb begin
        last = (cnt == LAST);
`ifdef MULT_SIGNED_EN
        m_ext = {m_reg[WIDTH-1], m_reg};
        if (!b_reg[0])
            p = {x_reg, a_reg};
        else if (last)
            p = {x_reg, a_reg} - m_ext;
        else
            p = {x_reg, a_reg} + m_ext;
`else
        m_ext = {1'b0, m_reg};
        p     = b_reg[0] ? ({x_reg, a_reg} + m_ext) : {x_reg, a_reg};
`endif
    end

    // Sequencer and datapath registers; {P,B} shifts right as one register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            m_reg <= '0;
            x_reg <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ClearA_LoadB) begin
                        a_reg <= '0;
                        x_reg <= 1'b0;
                        b_reg <= S;
                    end else if (Run) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    a_reg <= '0;
                    x_reg <= 1'b0;
                    m_reg <= S;
                    cnt   <= '0;
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    a_reg <= p[WIDTH:1];
                    b_reg <= {p[0], b_reg[WIDTH-1:1]};
`ifdef MULT_SIGNED_EN
                    // Arithmetic shift: the sign stays in X.
                    x_reg <= p[WIDTH];
`else
                    // The carry has moved into A's MSB; X is not part of the product.
                    x_reg <= 1'b0;
`endif
                    cnt   <= cnt + CW'(1);
                    if (last)
                        state <= DONE;
                end
                default: begin
                    // DONE: one multiply per Run press, wait for release.
                    if (!Run)
                        state <= IDLE;
                end
            endcase
        end
    end

    assign Aval = a_reg;
    assign Bval = b_reg;
    assign X    = x_reg;
    assign Busy = (state == CLEAR) || (state == COMPUTE);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed vectors for an 8-bit seq_multiplier with a
// scoreboard; a negedge monitor pops the expected product on each Done rise.
// Expected values follow the build selected by MULT_SIGNED_EN.

module tb_seq_multiplier;

    localparam int W = 8;
`ifdef MULT_SIGNED_EN
    localparam bit SIGNED = 1'b1;
`else
    localparam bit SIGNED = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         ClearA_LoadB = 1'b0;
    logic         Run = 1'b0;
    logic [W-1:0] S = '0;
    logic [W-1:0] Aval;
    logic [W-1:0] Bval;
    logic         X;
    logic         Busy;
    logic         Done;

    seq_multiplier #(.WIDTH(W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ClearA_LoadB (ClearA_LoadB),
        .Run          (Run),
        .S            (S),
        .Aval         (Aval),
        .Bval         (Bval),
        .X            (X),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         x;
        int           t0;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors = 0;
    int   cyc = 0;
    logic done_q = 1'b0;

    always @(posedge Clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: one scoreboard entry per Done rising edge; latency is counted
    // in clock edges from the edge that sampled Run through the Done edge.
    always @(negedge Clk) begin
        if (Done && !done_q) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_done: got Done=1, expected no pending multiply (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("prod_a", 32'(Aval), 32'(e.a));
                check("prod_b", 32'(Bval), 32'(e.b));
                check("prod_x", 32'(X), 32'(e.x));
                check("latency", 32'(cyc - e.t0), 32'(W + 2));
            end
        end
        done_q = Done;
    end

    task automatic load(input logic [W-1:0] v);
        @(negedge Clk);
        S = v;
        ClearA_LoadB = 1'b1;
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
        check("load_b", 32'(Bval), 32'(v));
        check("load_a", 32'(Aval), 32'h0);
        check("load_x", 32'(X), 32'h0);
    endtask

    task automatic mult(input logic [W-1:0] s, input logic [W-1:0] ea, input logic [W-1:0] eb,
                        input logic ex, input int hold, input bit disturb);
        int n;
        @(negedge Clk);
        S = s;
        Run = 1'b1;
        sb.push_back('{a: ea, b: eb, x: ex, t0: cyc});
        @(negedge Clk);
        check("busy_after_run", 32'(Busy), 32'h1);
        if (hold == 0) Run = 1'b0;
        if (disturb) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge Clk);
                S = W'($urandom);
                ClearA_LoadB = 1'b1;
            end
            @(negedge Clk);
            ClearA_LoadB = 1'b0;
        end
        n = 0;
        while (!Done && n < 40) begin
            @(negedge Clk);
            n++;
        end
        if (!Done) begin
            vectors++;
            errors++;
            $display("FAIL done_timeout: got Done=0 after %0d cycles, expected Done=1", n);
            sb.delete();
            Run = 1'b0;
            return;
        end
        check("busy_at_done", 32'(Busy), 32'h0);
        if (hold > 0) begin
            repeat (hold) @(negedge Clk);
            check("done_held", 32'(Done), 32'h1);
            check("held_b", 32'(Bval), 32'(eb));
            Run = 1'b0;
        end
        @(negedge Clk);
        check("done_drop", 32'(Done), 32'h0);
    endtask

    initial begin
        @(negedge Clk);
        check("rst_a", 32'(Aval), 32'h0);
        check("rst_b", 32'(Bval), 32'h0);
        check("rst_x", 32'(X), 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);
        check("rst_done", 32'(Done), 32'h0);
        Reset = 1'b0;
        @(negedge Clk);

        // 7 x 3 = 21
        load(8'h07);
        mult(8'h03, 8'h00, 8'h15, 1'b0, 0, 1'b0);
        // Run held 30 cycles: exactly one multiply of 0x15 x 1
        mult(8'h01, 8'h00, 8'h15, 1'b0, 30, 1'b0);
        // Chained: previous B (0x15) x 2
        mult(8'h02, 8'h00, 8'h2A, 1'b0, 0, 1'b0);
        // 0xFE x 0x07: -14 signed, 1778 unsigned
        load(8'hFE);
        mult(8'h07, SIGNED ? 8'hFF : 8'h06, 8'hF2, SIGNED, 0, 1'b0);
        // 0x80 x 0x80: +16384 in both builds
        load(8'h80);
        mult(8'h80, 8'h40, 8'h00, 1'b0, 0, 1'b0);
        // 0xFF x 0xFF: +1 signed, 0xFE01 unsigned
        load(8'hFF);
        mult(8'hFF, SIGNED ? 8'h00 : 8'hFE, 8'h01, 1'b0, 0, 1'b0);
        // 3 x 0xF9: -21 signed, 747 unsigned
        load(8'h03);
        mult(8'hF9, SIGNED ? 8'hFF : 8'h02, 8'hEB, SIGNED, 0, 1'b0);
        // S and ClearA_LoadB toggled during COMPUTE must not disturb 12 x 5
        load(8'h0C);
        mult(8'h05, 8'h00, 8'h3C, 1'b0, 0, 1'b1);

        // Reset in the middle of COMPUTE
        load(8'h55);
        @(negedge Clk);
        S = 8'h03;
        Run = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
        repeat (4) @(negedge Clk);
        check("mid_busy", 32'(Busy), 32'h1);
        Reset = 1'b1;
        #1;
        check("mid_rst_a", 32'(Aval), 32'h0);
        check("mid_rst_b", 32'(Bval), 32'h0);
        check("mid_rst_x", 32'(X), 32'h0);
        check("mid_rst_busy", 32'(Busy), 32'h0);
        check("mid_rst_done", 32'(Done), 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("post_rst_busy", 32'(Busy), 32'h0);

        // Normal operation after reset: 6 x 7 = 42
        load(8'h06);
        mult(8'h07, 8'h00, 8'h2A, 1'b0, 0, 1'b0);

        repeat (5) @(negedge Clk);
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
